// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: LSB-first frames of WIDTH bits with a one-word output buffer.
// Define SIPO_RX_PARITY_EN to append and check one even-parity bit per frame.
module sipo_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             sin,
    input  logic             pready,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             ovr,
    output logic             perr
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;
`else
    typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pvalid_q, pvalid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_done;

    assign shifted = {sin, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        pout_d    = pout_q;
        pvalid_d  = pvalid_q;
        ovr_d     = ovr_q;
        perr_d    = 1'b0;
        word      = shifted;
        word_done = 1'b0;

        if (!mode) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StData: begin
                    shreg_d = shifted;
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
                        state_d = StPar;
`else
                        state_d   = StIdle;
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StData;
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                StPar: begin
                    state_d = StIdle;
                    word    = shreg_q;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if (^{shreg_q, sin}) begin
                        perr_d = 1'b1;
                    end else begin
                        word_done = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        // A completed word may replace one being accepted on the same edge.
        if (word_done) begin
            if (!pvalid_q || pready) begin
                pout_d   = word;
                pvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (pvalid_q && pready) begin
            pvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shreg_q  <= '0;
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            pout_q   <= pout_d;
            pvalid_q <= pvalid_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
        end
    end

    assign pout   = pout_q;
    assign pvalid = pvalid_q;
    assign ovr    = ovr_q;
`ifdef SIPO_RX_PARITY_EN
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule
